// File: rtl/rhythm_note_spawner.sv
// Four-lane falling-note field: spawns rows from an LFSR word on each beat, scrolls, judges hits, keeps score/combo.
// Define RHYTHM_SINGLE_NOTE_EN to reduce each spawned row to the lowest set lane of the pattern.
module rhythm_note_spawner #(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned SONG_LEN = 64,
    parameter int unsigned SCORE_W  = 16
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Start,
    input  logic                  i_Beat,
    input  logic [7:0]            i_Rand,
    input  logic [3:0]            i_Density,
    input  logic [3:0]            i_Hit,
    output logic [4*ROWS-1:0]     o_Field,
    output logic [3:0]            o_Judge_Row,
    output logic                  o_Hit_Pulse,
    output logic                  o_Miss_Pulse,
    output logic [SCORE_W-1:0]    o_Score,
    output logic [7:0]            o_Combo,
    output logic                  o_Busy,
    output logic                  o_Done
);

    localparam int unsigned FW      = 4 * ROWS;
    localparam int unsigned CNT_MAX = (SONG_LEN > ROWS) ? SONG_LEN : ROWS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(SONG_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [FW-1:0]      field_q, field_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         combo_q, combo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic               miss_pulse_q, miss_pulse_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [3:0]         hit_vec;
    logic [3:0]         miss_vec;
    logic [2:0]         hit_cnt;
    logic [3:0]         pattern;
    logic [3:0]         spawn_row;
    logic [3:0]         top_row;
    logic [SCORE_W:0]   score_sum;
    logic [8:0]         combo_sum;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    always_comb begin
        pattern = i_Rand[7:4];
`ifdef RHYTHM_SINGLE_NOTE_EN
        spawn_row = pattern & (~pattern + 4'd1);
`else
        spawn_row = pattern;
`endif
        if (i_Rand[3:0] >= i_Density) begin
            spawn_row = 4'h0;
        end
    end

    always_comb begin
        state_d      = state_q;
        field_d      = field_q;
        score_d      = score_q;
        combo_d      = combo_q;
        cnt_d        = cnt_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        hit_vec      = '0;
        miss_vec     = '0;
        hit_cnt      = '0;
        top_row      = '0;
        score_sum    = '0;
        combo_sum    = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_Start) begin
                    state_d = S_RUN;
                    field_d = '0;
                    score_d = '0;
                    combo_d = '0;
                    cnt_d   = '0;
                end
            end

            S_RUN, S_DRAIN: begin
                // Hits are judged before the beat so a same-cycle hit is never also a miss.
                hit_vec  = i_Hit & field_q[3:0];
                miss_vec = field_q[3:0] & ~hit_vec;
                hit_cnt  = popcount4(hit_vec);

                field_d[3:0] = field_q[3:0] & ~hit_vec;

                score_sum = {1'b0, score_q} + (SCORE_W+1)'(hit_cnt);
                score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                combo_sum = {1'b0, combo_q} + 9'(hit_cnt);
                combo_d   = combo_sum[8] ? '1 : combo_sum[7:0];

                hit_pulse_d = |hit_vec;

                if (i_Beat) begin
                    if (|miss_vec) begin
                        combo_d      = '0;
                        miss_pulse_d = 1'b1;
                    end
                    top_row = (state_q == S_RUN) ? spawn_row : 4'h0;
                    field_d = {top_row, field_q[FW-1:4]};

                    if (state_q == S_RUN) begin
                        if (cnt_q == RUN_LAST) begin
                            state_d = S_DRAIN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        if (cnt_q == DRAIN_LAST) begin
                            state_d = S_DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q      <= S_IDLE;
            field_q      <= '0;
            score_q      <= '0;
            combo_q      <= '0;
            cnt_q        <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            field_q      <= field_d;
            score_q      <= score_d;
            combo_q      <= combo_d;
            cnt_q        <= cnt_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign o_Field      = field_q;
    assign o_Judge_Row  = field_q[3:0];
    assign o_Hit_Pulse  = hit_pulse_q;
    assign o_Miss_Pulse = miss_pulse_q;
    assign o_Score      = score_q;
    assign o_Combo      = combo_q;
    assign o_Busy       = busy_q;
    assign o_Done       = done_q;

endmodule

// File: tb/tb_rhythm_note_spawner.sv
// Directed bench for rhythm_note_spawner: a short-song instance for field/judge behaviour
// and a long-song narrow-score instance for saturation.
module tb_rhythm_note_spawner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        start, beat;
    logic [7:0]  rand_w;
    logic [3:0]  density, hit;
    logic [31:0] field;
    logic [3:0]  judge;
    logic        hit_p, miss_p, busy, done;
    logic [15:0] score;
    logic [7:0]  combo;

    logic        s_start, s_beat;
    logic [7:0]  s_rand;
    logic [3:0]  s_density, s_hit;
    logic [15:0] s_field;
    logic [3:0]  s_judge;
    logic        s_hit_p, s_miss_p, s_busy, s_done;
    logic [8:0]  s_score;
    logic [7:0]  s_combo;

    int checks = 0;
    int errors = 0;

    rhythm_note_spawner #(.ROWS(8), .SONG_LEN(4), .SCORE_W(16)) dut (
        .i_Clk(clk), .i_Rst(rst_n), .i_Start(start), .i_Beat(beat),
        .i_Rand(rand_w), .i_Density(density), .i_Hit(hit),
        .o_Field(field), .o_Judge_Row(judge), .o_Hit_Pulse(hit_p),
        .o_Miss_Pulse(miss_p), .o_Score(score), .o_Combo(combo),
        .o_Busy(busy), .o_Done(done)
    );

    rhythm_note_spawner #(.ROWS(4), .SONG_LEN(200), .SCORE_W(9)) dut_sat (
        .i_Clk(clk), .i_Rst(rst_n), .i_Start(s_start), .i_Beat(s_beat),
        .i_Rand(s_rand), .i_Density(s_density), .i_Hit(s_hit),
        .o_Field(s_field), .o_Judge_Row(s_judge), .o_Hit_Pulse(s_hit_p),
        .o_Miss_Pulse(s_miss_p), .o_Score(s_score), .o_Combo(s_combo),
        .o_Busy(s_busy), .o_Done(s_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_once(input logic [7:0] r, input logic [3:0] d, input logic [3:0] h);
        rand_w  = r;
        density = d;
        hit     = h;
        beat    = 1'b1;
        tick();
        beat    = 1'b0;
        hit     = 4'h0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int unsigned exp_score;
        int unsigned exp_combo;

        rst_n = 1'b0;
        start = 0; beat = 0; rand_w = 0; density = 0; hit = 0;
        s_start = 0; s_beat = 0; s_rand = 0; s_density = 0; s_hit = 0;
        repeat (3) tick();

        check("rst_field", field, 32'h0);
        check("rst_score", 32'(score), 32'h0);
        check("rst_combo", 32'(combo), 32'h0);
        check("rst_flags", {28'h0, busy, done, hit_p, miss_p}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Density 0 song: nothing spawns, 4 run beats + 8 drain beats
        pulse_start();
        check("t1_busy_start", 32'(busy), 32'h1);
        for (int k = 1; k <= 12; k++) begin
            beat_once(8'hF0, 4'd0, 4'h0);
            check("t1_field", field, 32'h0);
            check("t1_busy", 32'(busy), (k <= 11) ? 32'h1 : 32'h0);
            check("t1_done", 32'(done), (k == 12) ? 32'h1 : 32'h0);
        end
        check("t1_score", 32'(score), 32'h0);

        // Restart from DONE, spawn threshold checks
        pulse_start();
        check("t2_busy", 32'(busy), 32'h1);
        check("t2_done", 32'(done), 32'h0);
        beat_once(8'hA3, 4'd4, 4'h0);
        check("t2_spawn_a", field, 32'hA000_0000);
        beat_once(8'hA5, 4'd4, 4'h0);
        check("t2_nospawn", field, 32'h0A00_0000);
        pulse_start();
        check("t6_start_in_run", field, 32'h0A00_0000);
        check("t6_busy_in_run", 32'(busy), 32'h1);
        beat_once(8'h30, 4'd4, 4'h0);
        check("t3_spawn_3", field, 32'h30A0_0000);
        beat_once(8'h5F, 4'd15, 4'h0);
        check("t2_dens15_rand15", field, 32'h030A_0000);

        repeat (4) beat_once(8'hF0, 4'd15, 4'h0);
        check("drain_no_spawn", field, 32'h0000_030A);
        check("judge_a", 32'(judge), 32'hA);

        // Same-cycle hit and beat: partial hit, remaining note misses
        beat_once(8'hF0, 4'd15, 4'h2);
        check("t4_field", field, 32'h0000_0030);
        check("t4_score", 32'(score), 32'h1);
        check("t4_combo", 32'(combo), 32'h0);
        check("t4_hit_p", 32'(hit_p), 32'h1);
        check("t4_miss_p", 32'(miss_p), 32'h1);
        tick();
        check("t4_pulses_clear", {30'h0, hit_p, miss_p}, 32'h0);

        beat_once(8'hF0, 4'd15, 4'h0);
        check("t3_row0", 32'(judge), 32'h3);
        check("t3_no_miss_empty", 32'(miss_p), 32'h0);
        hit = 4'h7;
        tick();
        hit = 4'h0;
        check("t3_field", field, 32'h0);
        check("t3_score", 32'(score), 32'h3);
        check("t3_combo", 32'(combo), 32'h2);
        check("t3_hit_p", 32'(hit_p), 32'h1);
        tick();
        check("t3_hit_p_once", 32'(hit_p), 32'h0);
        hit = 4'h8;
        tick();
        hit = 4'h0;
        check("empty_hit_score", 32'(score), 32'h3);
        check("empty_hit_pulse", 32'(hit_p), 32'h0);

        beat_once(8'hF0, 4'd15, 4'h0);
        check("t3_next_no_miss", 32'(miss_p), 32'h0);
        check("t3_combo_kept", 32'(combo), 32'h2);
        check("drain7_busy", 32'(busy), 32'h1);
        beat_once(8'hF0, 4'd15, 4'h0);
        check("drain8_done", 32'(done), 32'h1);
        check("drain8_busy", 32'(busy), 32'h0);
        check("done_score", 32'(score), 32'h3);

        beat_once(8'hA3, 4'd4, 4'hF);
        check("done_field_held", field, 32'h0);
        check("done_score_held", 32'(score), 32'h3);
        check("done_still", 32'(done), 32'h1);

        // Restart from DONE clears score, then build a full chord stack
        pulse_start();
        check("t6_restart_score", 32'(score), 32'h0);
        check("t6_restart_combo", 32'(combo), 32'h0);
        repeat (8) beat_once(8'hF0, 4'd15, 4'h0);
        check("chord_stack", field, 32'h0000_FFFF);
        hit = 4'hF;
        tick();
        hit = 4'h0;
        check("chord_hit_field", field, 32'h0000_FFF0);
        check("chord_hit_score", 32'(score), 32'h4);
        check("chord_hit_combo", 32'(combo), 32'h4);

        // Saturation on the narrow-score instance
        s_density = 4'd15;
        s_rand    = 8'hF0;
        s_start   = 1'b1;
        tick();
        s_start   = 1'b0;
        s_beat    = 1'b1;
        repeat (4) tick();
        check("sat_field_full", 32'(s_field), 32'hFFFF);
        s_hit = 4'hF;
        for (int i = 1; i <= 129; i++) begin
            tick();
            exp_score = (4 * i > 511) ? 511 : 4 * i;
            exp_combo = (4 * i > 255) ? 255 : 4 * i;
            if (i == 63 || i == 64 || i == 65) begin
                check("sat_combo", 32'(s_combo), exp_combo);
            end
            if (i == 127 || i == 128 || i == 129) begin
                check("sat_score", 32'(s_score), exp_score);
            end
        end
        s_beat = 1'b0;
        s_hit  = 4'h0;
        check("sat_field", 32'(s_field), 32'hFFFF);
        check("sat_busy", 32'(s_busy), 32'h1);

        // Asynchronous reset with both instances mid-song
        rst_n = 1'b0;
        #2;
        check("t6_rst_field", field, 32'h0);
        check("t6_rst_score", 32'(score), 32'h0);
        check("t6_rst_combo", 32'(combo), 32'h0);
        check("t6_rst_flags", {28'h0, busy, done, hit_p, miss_p}, 32'h0);
        check("t6_rst_sat_field", 32'(s_field), 32'h0);
        check("t6_rst_sat_score", 32'(s_score), 32'h0);
        check("t6_rst_sat_combo", 32'(s_combo), 32'h0);
        check("t6_rst_sat_busy", 32'(s_busy), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(busy), 32'h0);
        beat_once(8'hA3, 4'd4, 4'h0);
        check("idle_beat_ignored", field, 32'h0);
        pulse_start();
        check("idle_start", 32'(busy), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
